// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter_if
// Brief    : CPU, loader and DataMemory signal bundle for dmem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    // CPU load/store path
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    // Loader / debug burst port
    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [3:0]        ldr_len;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_rvalid;
    logic              ldr_done;

    // DataMemory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // master: surrounding system (CPU, loader, DataMemory); slave: the arbiter
    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output ldr_req, ldr_we, ldr_addr, ldr_len, ldr_wdata,
        input  ldr_gnt, ldr_rdata, ldr_rvalid, ldr_done,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  ldr_req, ldr_we, ldr_addr, ldr_len, ldr_wdata,
        output ldr_gnt, ldr_rdata, ldr_rvalid, ldr_done,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Shares single-port DataMemory between CPU load/store and a burst
//            loader port. Define ARB_STARVE_GUARD_EN to enable loader
//            anti-starvation (forced grant after STARVE_LIMIT denied cycles).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic          CLOCK_50,
    input  wire logic          reset,
    dmem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_RDW = 2'd1,
        ST_LDR     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [3:0]        len_q,   len_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic              we_q,    we_d;
    logic              done_q,  done_d;
    logic              rpend_q, rpend_d;
    logic              rldr_q,  rldr_d;

    logic              w_cpu_req;
    logic              w_starve_win;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_we;
    logic              w_mem_re;
    logic              w_ldr_gnt;
    logic              w_ldr_done;
    logic              w_cpu_stall;
    logic              w_cpu_rvalid;

    assign w_cpu_req = bus.cpu_rd | bus.cpu_wr;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        done_d      = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_ldr_gnt   = 1'b0;
        w_ldr_done  = 1'b0;
        w_cpu_stall = 1'b0;

        // Outputs stay quiet for as long as reset is held, not just after the edge.
        if (reset) begin
            unique case (state_q)
                ST_IDLE: begin
                    w_ldr_done = done_q;
                    if (bus.ldr_req && (!w_cpu_req || w_starve_win)) begin
                        w_ldr_gnt   = 1'b1;
                        w_mem_addr  = bus.ldr_addr;
                        w_mem_we    = bus.ldr_we;
                        w_mem_re    = ~bus.ldr_we;
                        w_mem_wdata = bus.ldr_we ? bus.ldr_wdata : '0;
                        w_cpu_stall = w_cpu_req;
                        addr_d      = bus.ldr_addr + ADDR_W'(1);
                        len_d       = bus.ldr_len;
                        cnt_d       = 4'd1;
                        we_d        = bus.ldr_we;
                        if (bus.ldr_len == 4'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_LDR;
                        end
                    end else if (bus.cpu_wr) begin
                        w_mem_addr  = bus.cpu_addr;
                        w_mem_we    = 1'b1;
                        w_mem_wdata = bus.cpu_wdata;
                    end else if (bus.cpu_rd) begin
                        w_mem_addr  = bus.cpu_addr;
                        w_mem_re    = 1'b1;
                        w_cpu_stall = 1'b1;
                        state_d     = ST_CPU_RDW;
                    end
                end

                // Data returns now; the still-asserted cpu_rd is the same load.
                ST_CPU_RDW: begin
                    state_d = ST_IDLE;
                end

                ST_LDR: begin
                    w_cpu_stall = w_cpu_req;
                    if (bus.ldr_req) begin
                        w_ldr_gnt   = 1'b1;
                        w_mem_addr  = addr_q;
                        w_mem_we    = we_q;
                        w_mem_re    = ~we_q;
                        w_mem_wdata = we_q ? bus.ldr_wdata : '0;
                        addr_d      = addr_q + ADDR_W'(1);
                        cnt_d       = cnt_q + 4'd1;
                        if (cnt_q == len_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        w_ldr_done = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Return tag: remembers who issued the read so its data goes to the right port.
    always_comb begin
        rpend_d = w_mem_re;
        rldr_d  = w_mem_re & w_ldr_gnt;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            rpend_q <= 1'b0;
            rldr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            done_q  <= done_d;
            rpend_q <= rpend_d;
            rldr_q  <= rldr_d;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    logic [c_starve_w-1:0] starve_q, starve_d;

    assign w_starve_win = (starve_q == c_starve_max);

    // Saturates at the limit so a long-denied loader keeps its claim.
    always_comb begin
        starve_d = starve_q;
        if (w_ldr_gnt) begin
            starve_d = '0;
        end else if (bus.ldr_req && (starve_q != c_starve_max)) begin
            starve_d = starve_q + c_starve_w'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign w_starve_win = 1'b0;
`endif

    assign w_cpu_rvalid   = rpend_q & ~rldr_q;

    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_re     = w_mem_re;
    assign bus.ldr_gnt    = w_ldr_gnt;
    assign bus.ldr_done   = w_ldr_done;
    assign bus.cpu_stall  = w_cpu_stall;
    assign bus.cpu_rvalid = w_cpu_rvalid;
    assign bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.ldr_rvalid = rldr_q;
    assign bus.ldr_rdata  = rldr_q ? bus.mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Brief    : Directed + random bench for dmem_port_arbiter with a transaction
//            level reference model and an emulated DataMemory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int SL    = 8;
    localparam int DEPTH = 1 << AW;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic CLOCK_50 = 1'b0;
    logic reset;
    always #5 CLOCK_50 = ~CLOCK_50;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hA5C3_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Emulated DataMemory: synchronous write, one-cycle read latency.
    logic [DW-1:0] dmem [DEPTH];
    always @(posedge CLOCK_50) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= init_word(i);
        end else begin
            if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_re) bus.mem_rdata <= dmem[bus.mem_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int gcyc    = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %h, expected %h", tag, gcyc, obs, exp);
        end
    endtask

    // Agents: CPU operations and loader bursts, each consumed when the model says so.
    typedef struct { bit rd; bit wr; logic [AW-1:0] addr; logic [DW-1:0] d; } cop_t;
    typedef struct { bit we; logic [AW-1:0] addr; logic [3:0] len; int stop; logic [DW-1:0] base; } lop_t;
    cop_t cq[$];
    lop_t lq[$];
    int   lcnt;

    // Reference model: memory image, queue of outstanding burst addresses, pending returns.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [AW-1:0] bq[$];
    bit            bwe, cret, lret, dpend;
    logic [DW-1:0] cdat, ldat;
    int            starve;
    bit            n_cret, n_lret, n_dpend;
    logic [DW-1:0] n_cdat, n_ldat;
    bit            e_stall, e_crv, e_gnt, e_lrv, e_done, e_we, e_re;
    logic [DW-1:0] e_crd, e_lrd, e_wd;
    logic [AW-1:0] e_addr;

    // Logs of observed behaviour for the directed checks
    int            cyc;
    int            gnt_cyc[$];
    logic [AW-1:0] gnt_addr[$];
    int            done_cyc[$];
    logic [DW-1:0] lrd_log[$];
    logic [DW-1:0] crd_log[$];
    bit            stall_log[$];

    task automatic model_beat(input logic [AW-1:0] a);
        e_gnt  = 1'b1;
        e_addr = a;
        if (bwe) begin
            e_we       = 1'b1;
            e_wd       = bus.ldr_wdata;
            ref_mem[a] = bus.ldr_wdata;
        end else begin
            e_re   = 1'b1;
            n_lret = 1'b1;
            n_ldat = ref_mem[a];
        end
    endtask

    task automatic model_step();
        bit creq;
        creq  = bus.cpu_rd | bus.cpu_wr;
        n_cret = 0; n_lret = 0; n_dpend = 0; n_cdat = '0; n_ldat = '0;
        e_we = 0; e_re = 0; e_addr = '0; e_wd = '0; e_gnt = 0; e_done = 0; e_stall = 0;
        e_crv = cret; e_crd = cret ? cdat : '0;
        e_lrv = lret; e_lrd = lret ? ldat : '0;
        if (bq.size() != 0) begin
            e_stall = creq;
            if (bus.ldr_req) begin
                model_beat(bq.pop_front());
                if (bq.size() == 0) n_dpend = 1;
            end else begin
                bq.delete();
                e_done = 1;
            end
        end else if (!cret) begin
            e_done = dpend;
            if (bus.ldr_req && (!creq || (GUARD && starve >= SL))) begin
                bwe = bus.ldr_we;
                for (int i = 0; i <= int'(bus.ldr_len); i++)
                    bq.push_back(AW'((int'(bus.ldr_addr) + i) % DEPTH));
                model_beat(bq.pop_front());
                e_stall = creq;
                if (bq.size() == 0) n_dpend = 1;
            end else if (bus.cpu_wr) begin
                e_we   = 1; e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata;
                ref_mem[bus.cpu_addr] = bus.cpu_wdata;
            end else if (bus.cpu_rd) begin
                e_re   = 1; e_addr = bus.cpu_addr; e_stall = 1;
                n_cret = 1; n_cdat = ref_mem[bus.cpu_addr];
            end
        end
        if (e_gnt) starve = 0;
        else if (bus.ldr_req && starve < SL) starve++;
        cret = n_cret; cdat = n_cdat; lret = n_lret; ldat = n_ldat; dpend = n_dpend;
    endtask

    function automatic bit model_idle();
        return (bq.size() == 0) && !cret && !lret && !dpend;
    endfunction

    task automatic drive();
        if (cq.size() > 0) begin
            bus.cpu_rd = cq[0].rd; bus.cpu_wr = cq[0].wr;
            bus.cpu_addr = cq[0].addr; bus.cpu_wdata = cq[0].d;
        end else begin
            bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        end
        if (lq.size() > 0 && lcnt < lq[0].stop) begin
            bus.ldr_req = 1; bus.ldr_we = lq[0].we; bus.ldr_addr = lq[0].addr;
            bus.ldr_len = lq[0].len; bus.ldr_wdata = lq[0].base + DW'(lcnt);
        end else begin
            bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_len = '0; bus.ldr_wdata = '0;
        end
    endtask

    task automatic cycle();
        @(negedge CLOCK_50);
        model_step();
        chk("cpu_stall",  bus.cpu_stall,  e_stall);
        chk("cpu_rvalid", bus.cpu_rvalid, e_crv);
        chk("cpu_rdata",  bus.cpu_rdata,  e_crd);
        chk("ldr_gnt",    bus.ldr_gnt,    e_gnt);
        chk("ldr_rvalid", bus.ldr_rvalid, e_lrv);
        chk("ldr_rdata",  bus.ldr_rdata,  e_lrd);
        chk("ldr_done",   bus.ldr_done,   e_done);
        chk("mem_we",     bus.mem_we,     e_we);
        chk("mem_re",     bus.mem_re,     e_re);
        if (e_we || e_re) chk("mem_addr", bus.mem_addr, e_addr);
        if (e_we) chk("mem_wdata", bus.mem_wdata, e_wd);
        if (e_gnt) begin gnt_cyc.push_back(cyc); gnt_addr.push_back(bus.mem_addr); end
        if (e_done) done_cyc.push_back(cyc);
        if (e_lrv) lrd_log.push_back(bus.ldr_rdata);
        if (e_crv) crd_log.push_back(bus.cpu_rdata);
        stall_log.push_back(bus.cpu_stall);
        if (cq.size() > 0) begin
            if ((!cq[0].rd && !cq[0].wr) || (cq[0].wr && !e_stall) || (cq[0].rd && e_crv))
                cq.delete(0);
        end
        if (e_gnt) lcnt++;
        if (e_done && lq.size() > 0) begin lq.delete(0); lcnt = 0; end
        cyc++;
        gcyc++;
        @(posedge CLOCK_50);
        #1;
        drive();
    endtask

    task automatic run(input int maxc, input bit need_idle);
        int n;
        n = 0;
        drive();
        while (n < maxc && !(cq.size() == 0 && lq.size() == 0 && model_idle())) begin
            cycle();
            n++;
        end
        if (need_idle) chk("run_completes", 32'(cq.size() == 0 && lq.size() == 0 && model_idle()), 1);
    endtask

    task automatic clear_logs();
        cyc = 0;
        gnt_cyc.delete(); gnt_addr.delete(); done_cyc.delete();
        lrd_log.delete(); crd_log.delete(); stall_log.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        chk("rst_cpu_stall",  bus.cpu_stall,  0);
        chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("rst_cpu_rdata",  bus.cpu_rdata,  0);
        chk("rst_ldr_gnt",    bus.ldr_gnt,    0);
        chk("rst_ldr_rvalid", bus.ldr_rvalid, 0);
        chk("rst_ldr_rdata",  bus.ldr_rdata,  0);
        chk("rst_ldr_done",   bus.ldr_done,   0);
        chk("rst_mem_addr",   bus.mem_addr,   0);
        chk("rst_mem_wdata",  bus.mem_wdata,  0);
        chk("rst_mem_we",     bus.mem_we,     0);
        chk("rst_mem_re",     bus.mem_re,     0);
        cq.delete(); lq.delete(); lcnt = 0;
        bq.delete(); cret = 0; lret = 0; dpend = 0; starve = 0; bwe = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        drive();
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int first;
        reset = 1'b1;
        lcnt  = 0;
        drive();
        #2;
        apply_reset();

        // CPU write then read of the same word
        clear_logs();
        cq.push_back('{0, 1, 5'd3, 32'hDEADBEEF});
        cq.push_back('{1, 0, 5'd3, 32'h0});
        run(20, 1);
        chk("t1_wr_stall", 32'(stall_log[0]), 0);
        chk("t1_rd_stall", 32'(stall_log[1]), 1);
        chk("t1_ret_stall", 32'(stall_log[2]), 0);
        chk("t1_rdata", crd_log.size() > 0 ? crd_log[0] : 32'hX, 32'hDEADBEEF);

        // Loader write burst wrapping the address space, then read it back
        clear_logs();
        lq.push_back('{1, 5'd30, 4'd3, 4, 32'd1});
        run(30, 1);
        chk("t2_gnt_count", 32'(gnt_cyc.size()), 4);
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] ea [4];
            ea = '{5'd30, 5'd31, 5'd0, 5'd1};
            chk($sformatf("t2_addr%0d", i), i < gnt_addr.size() ? gnt_addr[i] : 5'h1F, ea[i]);
        end
        chk("t2_done_cyc", done_cyc.size() > 0 ? done_cyc[0] : -1, 4);
        clear_logs();
        lq.push_back('{0, 5'd30, 4'd3, 4, 32'd0});
        run(30, 1);
        chk("t2_rd_count", 32'(lrd_log.size()), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_rdata%0d", i), i < lrd_log.size() ? lrd_log[i] : 32'hX, 32'(i + 1));

        // Simultaneous CPU read and loader request
        clear_logs();
        cq.push_back('{1, 0, 5'd7, 32'h0});
        lq.push_back('{0, 5'd12, 4'd0, 1, 32'd0});
        run(30, 1);
        chk("t3_first_gnt", gnt_cyc.size() > 0 ? gnt_cyc[0] : -1, 2);

        // CPU access arriving during a 16-beat burst
        clear_logs();
        lq.push_back('{1, 5'd5, 4'd15, 16, 32'd100});
        cq.push_back('{0, 0, 5'd0, 32'h0});
        cq.push_back('{0, 0, 5'd0, 32'h0});
        cq.push_back('{0, 1, 5'd9, 32'h1234_5678});
        cq.push_back('{1, 0, 5'd9, 32'h0});
        run(60, 1);
        for (int i = 2; i < 16; i++) chk($sformatf("t4_stall%0d", i), 32'(stall_log[i]), 1);
        chk("t4_stall_release", 32'(stall_log[16]), 0);
        chk("t4_done_cyc", done_cyc.size() > 0 ? done_cyc[0] : -1, 16);
        chk("t4_rdata", crd_log.size() > 0 ? crd_log[0] : 32'hX, 32'h1234_5678);

        // Loader aborts a len-7 burst after two beats
        clear_logs();
        lq.push_back('{0, 5'd10, 4'd7, 2, 32'd0});
        run(30, 1);
        chk("t5_gnt_count", 32'(gnt_cyc.size()), 2);
        chk("t5_done_cyc", done_cyc.size() > 0 ? done_cyc[0] : -1, 2);

        // Back-to-back CPU reads against a waiting loader
        clear_logs();
        for (int i = 0; i < 10; i++) cq.push_back('{1, 0, AW'($urandom_range(0, DEPTH - 1)), 32'h0});
        lq.push_back('{0, 5'd20, 4'd0, 1, 32'd0});
        run(80, 1);
        first = gnt_cyc.size() > 0 ? gnt_cyc[0] : -1;
        chk("t6_starve_gnt", first, GUARD ? 8 : 20);

        // Reset in the middle of a burst
        clear_logs();
        lq.push_back('{1, 5'd0, 4'd15, 16, 32'd500});
        run(6, 0);
        apply_reset();
        clear_logs();
        repeat (3) cycle();
        chk("t6_no_done", 32'(done_cyc.size()), 0);

        // Random mixed traffic
        clear_logs();
        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 3);
            cq.push_back('{k == 1, k >= 2, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom)});
        end
        for (int i = 0; i < 14; i++) begin
            lop_t b;
            b.we   = 1'($urandom_range(0, 1));
            b.addr = AW'($urandom_range(0, DEPTH - 1));
            b.len  = 4'($urandom_range(0, 15));
            b.stop = (b.len != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, int'(b.len)) : int'(b.len) + 1;
            b.base = DW'($urandom);
            lq.push_back(b);
        end
        run(2500, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
